rx_unit: RTL

UART receive stage that consumes the serial line produced by tx_top; in loopback benches it connects directly to o_tx. It uses 16x oversampling and the same run-time framing controls as the transmitter: 7/8 data bits, 1/2 stop bits, none/even/odd parity and four baud rates. Each received word is presented in a one-entry output register with a valid/read handshake, per-word parity and framing flags, and a sticky overrun flag.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/rx_unit_if.sv | 24 ++
 rtl/rx_baud_gen.sv | 45 ++++
 rtl/rx_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line-rate and parity encodings, receiver FSM
// states, and the oversampling divisor calculation used by both the
// receiver and the transmitter.
package uart_pkg;

   // Receiver and transmitter both run 16 ticks per bit.
   localparam int OVERSAMPLE = 16;

   typedef enum logic [1:0] {
      BAUD_1200 = 2'b00,
      BAUD_2400 = 2'b01,
      BAUD_4800 = 2'b10,
      BAUD_9600 = 2'b11
   } baud_e;

   // 2'b11 is decoded as "no parity", the same as PAR_NONE.
   typedef enum logic [1:0] {
      PAR_NONE     = 2'b00,
      PAR_EVEN     = 2'b01,
      PAR_ODD      = 2'b10,
      PAR_NONE_ALT = 2'b11
   } parity_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   // Line rate for a 2-bit rate code: 1200 doubled per step.
   function automatic int baud_of(input int code);
      return 1200 << code;
   endfunction

   // Clocks per oversampling tick, rounded up so the tick is never fast.
   function automatic int baud_div(input int clk_freq, input int baud);
      return (clk_freq + baud * OVERSAMPLE - 1) / (baud * OVERSAMPLE);
   endfunction

endpackage

// File: rtl/rx_unit_if.sv
// Read-side bus of the UART receiver: one held word with its flags and a
// pop strobe from the consumer.
interface rx_unit_if #(
   parameter int DBITS = 8
);
   logic [DBITS-1:0] rd_data;
   logic             valid;
   logic             par_err;
   logic             frm_err;
   logic             ovr_err;
   logic             rd;

   // Receiver side: presents the word, accepts the pop strobe.
   modport master (
      output rd_data, valid, par_err, frm_err, ovr_err,
      input  rd
   );

   // Consumer side.
   modport slave (
      input  rd_data, valid, par_err, frm_err, ovr_err,
      output rd
   );
endinterface

// File: rtl/rx_baud_gen.sv
// Oversampling tick generator. The counter is held at zero while disabled
// so the first tick after enable lands a full divisor period later, which
// keeps samples aligned to the detected start edge.
module rx_baud_gen
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [1:0] bd_rate,
   output logic       tick
);

   // The slowest rate needs the largest divisor and sets the counter width.
   localparam int DIV_MAX = baud_div(CLK_FREQ, baud_of(0));
   localparam int CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

   logic [CNT_W-1:0] div_tab [4];
   logic [CNT_W-1:0] div_m1;
   logic [CNT_W-1:0] cnt_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div
         assign div_tab[gi] = CNT_W'(baud_div(CLK_FREQ, baud_of(gi)) - 1);
      end
   endgenerate

   assign div_m1 = div_tab[bd_rate];
   assign tick   = enable && (cnt_reg == div_m1);

   // Free-running divide-by-DIV counter, parked at zero when disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (!enable || (cnt_reg == div_m1)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/rx_unit.sv
// UART receiver with 16x oversampling, run-time framing selection
// (7/8 data, 1/2 stop, none/even/odd parity, four rates) and a one-entry
// output register with valid/pop handshake and error flags.
module rx_unit
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int DBITS    = 8,
   parameter int SBITS    = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_rx,
   input  logic       i_d_num,
   input  logic       i_s_num,
   input  logic [1:0] i_par,
   input  logic [1:0] i_bd_rate,
   rx_unit_if.master  bus
);

   localparam int BIT_W  = $clog2(DBITS);
   localparam int STOP_W = (SBITS > 1) ? $clog2(SBITS) : 1;

   // Line synchronizer plus one history flop for edge detection.
   logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

   // Frame FSM state and the per-frame configuration snapshot.
   rx_state_e          state_reg, state_next;
   logic [3:0]         tick_cnt_reg, tick_cnt_next;
   logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
   logic [STOP_W-1:0]  stop_cnt_reg, stop_cnt_next;
   logic [DBITS-1:0]   data_reg, data_next;
   logic               pend_par_reg, pend_par_next;
   logic               pend_frm_reg, pend_frm_next;
   logic               done_reg, done_next;
   logic               d_num_reg, d_num_next;
   logic               s_num_reg, s_num_next;
   parity_e            par_reg, par_next;
   logic [1:0]         bd_reg, bd_next;

   // Held output word.
   logic [DBITS-1:0]   held_data_reg;
   logic               held_par_reg, held_frm_reg;
   logic               valid_reg, ovr_reg;

   logic               tick;
   logic               baud_en;
   logic               start_edge;
   logic               par_en;
   logic [BIT_W-1:0]   last_bit;
   logic [STOP_W-1:0]  last_stop;

   assign baud_en    = (state_reg != IDLE);
   assign start_edge = rx_prev_reg && !rx_sync_reg;
   assign par_en     = (par_reg == PAR_EVEN) || (par_reg == PAR_ODD);
   assign last_bit   = d_num_reg ? BIT_W'(DBITS - 1) : BIT_W'(DBITS - 2);
   assign last_stop  = s_num_reg ? STOP_W'(SBITS - 1) : '0;

   rx_baud_gen #(
      .CLK_FREQ (CLK_FREQ)
   ) u_baud_gen (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .enable  (baud_en),
      .bd_rate (bd_reg),
      .tick    (tick)
   );

   // Two-flop synchronizer on the serial line; idles high out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= i_rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   // Frame FSM registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg    <= IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         stop_cnt_reg <= '0;
         data_reg     <= '0;
         pend_par_reg <= 1'b0;
         pend_frm_reg <= 1'b0;
         done_reg     <= 1'b0;
         d_num_reg    <= 1'b0;
         s_num_reg    <= 1'b0;
         par_reg      <= PAR_NONE;
         bd_reg       <= 2'b00;
      end else begin
         state_reg    <= state_next;
         tick_cnt_reg <= tick_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         stop_cnt_reg <= stop_cnt_next;
         data_reg     <= data_next;
         pend_par_reg <= pend_par_next;
         pend_frm_reg <= pend_frm_next;
         done_reg     <= done_next;
         d_num_reg    <= d_num_next;
         s_num_reg    <= s_num_next;
         par_reg      <= par_next;
         bd_reg       <= bd_next;
      end
   end

   // Frame FSM next state: sample mid-bit, assemble LSB-first, check
   // parity and stop bits, and flag completion for the output stage.
   always_comb begin
      state_next    = state_reg;
      tick_cnt_next = tick_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      stop_cnt_next = stop_cnt_reg;
      data_next     = data_reg;
      pend_par_next = pend_par_reg;
      pend_frm_next = pend_frm_reg;
      done_next     = 1'b0;
      d_num_next    = d_num_reg;
      s_num_next    = s_num_reg;
      par_next      = par_reg;
      bd_next       = bd_reg;

      case (state_reg)
         IDLE: begin
            // Only a 1->0 transition starts a frame; a held-low line does not.
            if (start_edge) begin
               state_next    = START;
               tick_cnt_next = '0;
               data_next     = '0;
               pend_par_next = 1'b0;
               pend_frm_next = 1'b0;
               d_num_next    = i_d_num;
               s_num_next    = i_s_num;
               par_next      = parity_e'(i_par);
               bd_next       = i_bd_rate;
            end
         end

         START: begin
            if (tick) begin
               if (tick_cnt_reg == 4'd7) begin
                  tick_cnt_next = '0;
                  if (!rx_sync_reg) begin
                     state_next   = DATA;
                     bit_cnt_next = '0;
                  end else begin
                     // Glitch shorter than half a bit: abandon silently.
                     state_next = IDLE;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (tick_cnt_reg == 4'd15) begin
                  tick_cnt_next          = '0;
                  data_next[bit_cnt_reg] = rx_sync_reg;
                  if (bit_cnt_reg == last_bit) begin
                     state_next    = par_en ? PARITY : STOP;
                     stop_cnt_next = '0;
                  end else begin
                     bit_cnt_next = bit_cnt_reg + 1'b1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

         PARITY: begin
            if (tick) begin
               if (tick_cnt_reg == 4'd15) begin
                  tick_cnt_next = '0;
                  // Unused upper data bits are zero, so they do not disturb the XOR.
                  pend_par_next = ((^data_reg) ^ rx_sync_reg) != (par_reg == PAR_ODD);
                  state_next    = STOP;
                  stop_cnt_next = '0;
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

         STOP: begin
            if (tick) begin
               if (tick_cnt_reg == 4'd15) begin
                  tick_cnt_next = '0;
                  if (!rx_sync_reg) begin
                     pend_frm_next = 1'b1;
                  end
                  if (stop_cnt_reg == last_stop) begin
                     // Back to IDLE now so an immediately following start edge is seen.
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end else begin
                     stop_cnt_next = stop_cnt_reg + 1'b1;
                  end
               end else begin
                  tick_cnt_next = tick_cnt_reg + 4'd1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output register: load on completion, pop on rd, track overwrites.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         held_data_reg <= '0;
         held_par_reg  <= 1'b0;
         held_frm_reg  <= 1'b0;
         valid_reg     <= 1'b0;
         ovr_reg       <= 1'b0;
      end else if (done_reg) begin
         held_data_reg <= data_reg;
         held_par_reg  <= pend_par_reg;
         held_frm_reg  <= pend_frm_reg;
         valid_reg     <= 1'b1;
         if (valid_reg && !bus.rd) begin
            ovr_reg <= 1'b1;
         end else if (valid_reg && bus.rd) begin
            ovr_reg <= 1'b0;
         end
      end else if (bus.rd && valid_reg) begin
         valid_reg <= 1'b0;
         ovr_reg   <= 1'b0;
      end
   end

   assign bus.rd_data = held_data_reg;
   assign bus.valid   = valid_reg;
   assign bus.par_err = held_par_reg;
   assign bus.frm_err = held_frm_reg;
   assign bus.ovr_err = ovr_reg;

endmodule
